rf_dump_reader: RTL and testbench



---
 rtl/rf_dump_pkg.sv | 18 +
 rtl/rf_dump_reader.sv | 139 +++++++++++++
 tb/tb_rf_dump_reader.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/rf_dump_pkg.sv
// Shared types and default sizing for the register-file dump reader.
// RF_DUMP_CHECKSUM_EN (optional) enables the trailing checksum beat in rf_dump_reader.
package rf_dump_pkg;

    localparam int RF_DUMP_NREGS = 16;
    localparam int RF_DW         = 32;
    localparam int RF_AW         = 5;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND_LO,
        SEND_HI,
        CSUM,
        DONE
    } rf_dump_state_t;

endpackage

// File: rtl/rf_dump_reader.sv
// Walks the register file two registers at a time and streams each word over valid/ready.
// Define RF_DUMP_CHECKSUM_EN to append an XOR checksum beat after the last register.
module rf_dump_reader
    import rf_dump_pkg::*;
#(
    parameter int NREGS = RF_DUMP_NREGS,
    parameter int DW    = RF_DW,
    parameter int AW    = RF_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rf_a1,
    output logic [AW-1:0] rf_a2,
    input  logic [DW-1:0] rf_rd1,
    input  logic [DW-1:0] rf_rd2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_idx,
    output logic          out_last
);

    rf_dump_state_t state_q, state_d;
    logic [AW-1:0]  ptr_q, ptr_d;
    logic [DW-1:0]  lo_buf, hi_buf;
    logic           final_pair;

    // Compared modulo 2^AW so NREGS == 2^AW still terminates.
    assign final_pair = (ptr_q + AW'(2)) == AW'(NREGS);

`ifdef RF_DUMP_CHECKSUM_EN
    logic [DW-1:0] csum;

    always_ff @(posedge clk) begin
        if (reset) begin
            csum <= '0;
        end else if (state_q == IDLE && start) begin
            csum <= '0;
        end else if (out_valid && out_ready && state_q != CSUM) begin
            csum <= csum ^ out_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            lo_buf  <= '0;
            hi_buf  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (state_q == FETCH) begin
                lo_buf <= rf_rd1;
                hi_buf <= rf_rd2;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rf_a1     = '0;
        rf_a2     = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        done      = 1'b0;
        busy      = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    ptr_d   = '0;
                end
            end
            FETCH: begin
                rf_a1   = ptr_q;
                rf_a2   = ptr_q + AW'(1);
                state_d = SEND_LO;
            end
            SEND_LO: begin
                out_valid = 1'b1;
                out_data  = lo_buf;
                out_idx   = ptr_q;
                if (out_ready) begin
                    state_d = SEND_HI;
                end
            end
            SEND_HI: begin
                out_valid = 1'b1;
                out_data  = hi_buf;
                out_idx   = ptr_q + AW'(1);
`ifdef RF_DUMP_CHECKSUM_EN
                out_last  = 1'b0;
`else
                out_last  = final_pair;
`endif
                if (out_ready) begin
                    if (final_pair) begin
`ifdef RF_DUMP_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = DONE;
`endif
                    end else begin
                        ptr_d   = ptr_q + AW'(2);
                        state_d = FETCH;
                    end
                end
            end
`ifdef RF_DUMP_CHECKSUM_EN
            CSUM: begin
                out_valid = 1'b1;
                out_data  = csum;
                out_idx   = AW'(NREGS);
                out_last  = 1'b1;
                if (out_ready) begin
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed bench for rf_dump_reader with an inline register-file model.
// Honours RF_DUMP_CHECKSUM_EN to expect the extra checksum beat.
module tb_rf_dump_reader;
    import rf_dump_pkg::*;

    localparam int NREGS = RF_DUMP_NREGS;
    localparam int DW    = RF_DW;
    localparam int AW    = RF_AW;
`ifdef RF_DUMP_CHECKSUM_EN
    localparam int NBEATS = NREGS + 1;
`else
    localparam int NBEATS = NREGS;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          busy, done;
    logic [AW-1:0] rf_a1, rf_a2;
    logic [DW-1:0] rf_rd1, rf_rd2;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_idx;
    logic          out_last;

    logic [DW-1:0] rf [32];
    assign rf_rd1 = rf[rf_a1];
    assign rf_rd2 = rf[rf_a2];

    int n_asserts = 0;
    int n_fails   = 0;

    always #5 clk = ~clk;

    rf_dump_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rf_a1     (rf_a1),
        .rf_a2     (rf_a2),
        .rf_rd1    (rf_rd1),
        .rf_rd2    (rf_rd2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload();
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? '0 : DW'(32'h100 + i);
    endtask

    // mode: 0 basic, 1 backpressure 1,0,0,1, 2 start at idx 5, 3 write reg 12 at idx 3
    task automatic run_dump(input int mode, input string name);
        logic [DW-1:0] exp_data [NBEATS];
        logic [DW-1:0] exp_csum;
        logic [DW-1:0] got_data [$];
        logic [AW-1:0] got_idx [$];
        logic          got_last [$];
        logic [DW-1:0] prev_data;
        logic [AW-1:0] prev_idx;
        logic          prev_last, prev_stall, restarted;
        int            last_xfer, done_cyc, done_cnt;

        preload();
        exp_csum = '0;
        for (int i = 0; i < NREGS; i++) begin
            exp_data[i] = (i == 0) ? '0 : DW'(32'h100 + i);
            if (mode == 3 && i == 12) exp_data[i] = 32'hDEADBEEF;
            exp_csum ^= exp_data[i];
        end
`ifdef RF_DUMP_CHECKSUM_EN
        exp_data[NREGS] = exp_csum;
`endif
        prev_stall = 1'b0;
        restarted  = 1'b0;
        prev_data  = '0;
        prev_idx   = '0;
        prev_last  = 1'b0;
        last_xfer  = -10;
        done_cyc   = -1;
        done_cnt   = 0;

        @(negedge clk);
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy_after_start"}, busy, 1);
        check({name, "_valid_cycle1"}, out_valid, 0);
        @(negedge clk);
        check({name, "_valid_cycle2"}, out_valid, 1);

        for (int cyc = 2; cyc < 400; cyc++) begin
            out_ready = (mode == 1) ? (cyc % 4 == 2 || cyc % 4 == 1) : 1'b1;
            if (prev_stall) begin
                check({name, "_stall_valid"}, out_valid, 1);
                check({name, "_stall_data"}, out_data, prev_data);
                check({name, "_stall_idx"}, out_idx, prev_idx);
                check({name, "_stall_last"}, out_last, prev_last);
            end
            start = 1'b0;
            if (mode == 2 && out_valid && out_idx == 5 && !restarted) begin
                start     = 1'b1;
                restarted = 1'b1;
            end
            if (mode == 3 && out_valid && out_idx == 3) rf[12] = 32'hDEADBEEF;
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_cyc = cyc;
                    check({name, "_busy_at_done"}, busy, 1);
                end
            end
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_idx.push_back(out_idx);
                got_last.push_back(out_last);
                last_xfer = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_idx   = out_idx;
            prev_last  = out_last;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            @(negedge clk);
        end
        start     = 1'b0;
        out_ready = 1'b0;

        check({name, "_beat_count"}, got_data.size(), NBEATS);
        check({name, "_done_count"}, done_cnt, 1);
        check({name, "_done_latency"}, done_cyc, last_xfer + 1);
        check({name, "_busy_after_done"}, busy, 0);
        for (int i = 0; i < NBEATS; i++) begin
            check({name, "_idx"}, (i < got_idx.size()) ? got_idx[i] : 'x, AW'(i));
            check({name, "_data"}, (i < got_data.size()) ? got_data[i] : 'x, exp_data[i]);
            check({name, "_last"}, (i < got_last.size()) ? got_last[i] : 1'bx,
                  (i == NBEATS - 1));
        end
    endtask

    initial begin
        logic found;
        preload();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        check("rst_idx", out_idx, 0);
        check("rst_a1", rf_a1, 0);
        check("rst_a2", rf_a2, 0);
        reset = 1'b0;

        run_dump(0, "basic");
        run_dump(1, "backpressure");
        run_dump(2, "start_busy");
        run_dump(3, "conc_write");

        // Reset while the idx-7 beat is stalled.
        preload();
        @(negedge clk);
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (out_valid && out_idx == 7) begin
                out_ready = 1'b0;
                found     = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("midrst_reached_idx7", found, 1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_a1", rf_a1, 0);
        check("midrst_a2", rf_a2, 0);
        reset = 1'b0;
        run_dump(0, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
